// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the memory port arbiter
package mem_arb_pkg;

    // Port-B read owner; also the encoding of the round-robin last_grant flop.
    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_e;

    // One slot of the read-return tag pipeline.
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    // Two byte ranges of one word each overlap when their start addresses
    // differ by at most this many bytes in either direction.
    localparam int unsigned WORD_SPAN = 3;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with a fetch hold mask
import mem_arb_pkg::*;

module rr_arbiter2 (
    input  logic       clk,     // system clock
    input  logic       rst,     // synchronous active-high reset
    input  logic [1:0] req,     // bit 0 fetch, bit 1 load
    input  logic       hold_if, // suppress the fetch request this cycle
    output logic [1:0] grant    // one-hot grant, same bit order as req
);

    owner_e     last_grant;
    logic [1:0] eff_req;

    // A held fetch does not take part in the contest at all, so it neither
    // wins nor moves the round-robin pointer.
    assign eff_req = req & {1'b1, ~hold_if};

    always_comb begin
        grant = eff_req;
        if (eff_req == 2'b11) begin
            grant = (last_grant == OWNER_LS) ? 2'b01 : 2'b10;
        end
    end

    // Pointer moves only when both requesters actually contended.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWNER_LS;
        end else if (eff_req == 2'b11) begin
            last_grant <= (last_grant == OWNER_LS) ? OWNER_IF : OWNER_LS;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares a dual-port memory group between fetch and load/store
import mem_arb_pkg::*;

module memory_port_arbiter #(
    parameter int DATA_DEPTH   = 4096,                  // words per bank
    parameter int ADDR_W       = 2 + $clog2(DATA_DEPTH), // byte address width
    parameter int READ_LATENCY = 2                      // addr_b edge to read_data, 1..4
) (
    input  logic              clk,            // system clock
    input  logic              rst,            // synchronous active-high reset
    // fetch request / response
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    // load/store request / response
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_req_write,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [3:0]        ls_req_wmask,
    input  logic [31:0]       ls_req_wdata,
    output logic              ls_rsp_valid,
    output logic [31:0]       ls_rsp_data,
    // memory group
    output logic [3:0]        mem_write_mask,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    logic              store_acc;
    logic              load_req;
    logic              fetch_req;
    logic              hazard;
    logic [ADDR_W-1:0] diff_fa;
    logic [ADDR_W-1:0] diff_af;
    logic [1:0]        grant;
    rd_tag_t           new_tag;
    rd_tag_t           head_tag;
    rd_tag_t           tag_q [READ_LATENCY];

    // Stores are never stalled, so a valid store is an accepted store.
    assign store_acc = !rst && ls_req_valid && ls_req_write;
    assign load_req  = !rst && ls_req_valid && !ls_req_write;
    assign fetch_req = !rst && if_req_valid;

    // Modular differences make the overlap test wrap across the top of the
    // address space for free.
    assign diff_fa = if_req_addr - ls_req_addr;
    assign diff_af = ls_req_addr - if_req_addr;
    assign hazard  = store_acc && fetch_req &&
                     ((diff_fa <= ADDR_W'(WORD_SPAN)) || (diff_af <= ADDR_W'(WORD_SPAN)));

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({load_req, fetch_req}),
        .hold_if (hazard),
        .grant   (grant)
    );

    assign if_req_ready = grant[0];
    assign ls_req_ready = !rst && (ls_req_write || grant[1]);

    // Port A: write path, zeroed whenever no store is accepted.
    assign mem_write_mask = store_acc ? ls_req_wmask : 4'b0000;
    assign mem_addr_a     = store_acc ? ls_req_addr  : '0;
    assign mem_write_data = store_acc ? ls_req_wdata : '0;

    // Port B: read path, at most one grant per cycle.
    always_comb begin
        mem_addr_b = '0;
        if (grant[0]) begin
            mem_addr_b = if_req_addr;
        end else if (grant[1]) begin
            mem_addr_b = ls_req_addr;
        end
    end

    assign new_tag.valid = |grant;
    assign new_tag.owner = grant[1] ? OWNER_LS : OWNER_IF;

    // Tag slot i holds the grant made i+1 cycles ago; the last slot lines up
    // with mem_read_data for that grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '{valid: 1'b0, owner: OWNER_IF};
            end
        end else begin
            tag_q[0] <= new_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign head_tag = tag_q[READ_LATENCY-1];

    // Gated by rst so nothing leaks out during the reset cycle itself.
    assign if_rsp_valid = !rst && head_tag.valid && (head_tag.owner == OWNER_IF);
    assign ls_rsp_valid = !rst && head_tag.valid && (head_tag.owner == OWNER_LS);
    assign if_rsp_data  = if_rsp_valid ? mem_read_data : 32'h0;
    assign ls_rsp_data  = ls_rsp_valid ? mem_read_data : 32'h0;

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares one dual-port memory group between the instruction-fetch unit (read-only) and the load/store unit (read or write).
- Port A of the group carries LSU stores. Port B carries the loads and fetches, arbitrated round-robin.
- Routes read data back to the owning requester after the group's read latency, and stalls fetches that overlap a same-cycle store.

Parameters:
- DATA_DEPTH, 4096: words per bank. Must match the memory group instance.
- ADDR_W, 2+$clog2(DATA_DEPTH): byte-address width, derived.
- READ_LATENCY, 2: cycles from the mem_addr_b edge to valid mem_read_data (1 bank + 1 output register). Range 1 to 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch accepted this cycle
- if_req_addr  in  ADDR_W  fetch byte address (misaligned allowed)
- if_rsp_valid  out  1  fetch data valid
- if_rsp_data  out  32  fetch data
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU accepted this cycle
- ls_req_write  in  1  1 = store, 0 = load
- ls_req_addr  in  ADDR_W  LSU byte address
- ls_req_wmask  in  4  store byte mask, software byte order
- ls_req_wdata  in  32  store data
- ls_rsp_valid  out  1  load data valid
- ls_rsp_data  out  32  load data
- mem_write_mask  out  4  to group write_mask
- mem_addr_a  out  ADDR_W  to group addr_a (write address)
- mem_addr_b  out  ADDR_W  to group addr_b (read address)
- mem_write_data  out  32  to group write_data
- mem_read_data  in  32  from group read_data

Behaviour:
- Handshake: a request is accepted when valid && ready on a rising edge. Responses have no backpressure; requesters must sink every rsp_valid pulse.
- Stores:
  - ls_req_ready = !rst for stores; stores are never stalled.
  - On an accepted store, drive mem_addr_a = ls_req_addr, mem_write_mask = ls_req_wmask, mem_write_data = ls_req_wdata combinationally in that cycle.
  - Otherwise drive mem_write_mask = 0, and mem_addr_a and mem_write_data = 0.
  - Stores produce no response.
- Reads: at most one port-B read per cycle. Candidates are a fetch and/or an LSU load.
- Arbitration: round-robin using a 1-bit last_grant register.
  - When both contend, grant the requester that was not granted last.
  - A lone requester is always granted, subject to the hazard rule below.
  - last_grant updates only on a contested grant.
  - Reset value: LSU, so the first tie goes to fetch.
- Hazard rule:
  - A fetch is not granted while the same cycle carries an accepted store whose byte range [a, a+3] overlaps [f, f+3].
  - Overlap test: (f−a) mod 2^ADDR_W ≤ 3 or (a−f) mod 2^ADDR_W ≤ 3.
  - In that case if_req_ready = 0 for that cycle only.
  - A load cannot collide with a store, because the LSU issues one operation per cycle.
- Write visibility: a store written at edge N is visible to a read whose mem_addr_b is presented in cycle N+1.
- mem_addr_b equals the granted address, or 0 when idle.
- Response routing:
  - A tag shift register of depth READ_LATENCY holds {valid, owner} and is pushed every cycle with the grant.
  - When the head entry is valid, assert the owner's rsp_valid for 1 cycle with rsp_data = mem_read_data.
  - Responses return in issue order.
  - Throughput: 1 read per cycle sustained; latency from accept to rsp_valid = READ_LATENCY.
- Reset:
  - Clears the tag pipeline and last_grant.
  - Holds both ready outputs and both rsp_valid outputs at 0; rsp_data outputs are 0.
  - Mid-operation reset drops in-flight reads: no rsp_valid in any cycle after rst is sampled high.
- Address wrap: addresses wrap modulo 2^ADDR_W in the overlap test. The group handles the bank wrap itself.

Decomposition:
- Package mem_arb_pkg: typedef owner_e {OWNER_IF, OWNER_LS}; typedef rd_tag_t {logic valid; owner_e owner;}.
- Sub-module rr_arbiter2: 2-way round-robin with a last_grant flop. It takes req[1:0] and a hold_if mask and returns grant[1:0].
- Tag pipeline and overlap check stay inline.

Test Plan:
1. Fetch only: fetches to 0x000, 0x004 and 0x008 on consecutive cycles, memory preloaded with 0x11111111, 0x22222222, 0x33333333 → if_rsp_valid on cycles 2, 3, 4 with that data in order; ls_rsp_valid stays 0.
2. Contention: both request reads every cycle for 6 cycles (fetch 0x100, load 0x200) → grants alternate IF, LS, IF, LS, IF, LS; each requester receives 3 responses, correctly routed.
3. Store then load: store 0xDEADBEEF with mask 0xF to 0x013 (misaligned) in cycle 0, load 0x013 in cycle 1 → ls_rsp_data = 0xDEADBEEF in cycle 3.
4. Fetch-store hazard: in the same cycle, store to 0x010 and fetch 0x012 → if_req_ready = 0, fetch granted the next cycle and returns the new data. A fetch of 0x014 alongside a store to 0x010 is granted with no stall.
5. Wrap overlap: store to 2^ADDR_W−2 with a fetch of 0x001 in the same cycle → stall detected.
6. Reset mid-flight: issue a load, assert rst for 1 cycle one cycle later → no ls_rsp_valid afterwards; after reset the first contested grant goes to fetch.
